proj2_mode_cnt: RTL and testbench
=================================

PROJ2_MODE_CNT -- requirements
Module: proj2_mode_cnt

Interface
REQ-001 SHALL have parameter DATABIT, default 8: width of count value, start value and lap length.
REQ-002 SHALL have parameter STEPBIT, default 4: width of step input.
REQ-003 SHALL have parameter LAPBIT, default 8: width of lap counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_run  input  1  start request; accepted only in IDLE.
REQ-007 SHALL have port i_num_cnt  input  DATABIT  lap length N (ticks per lap); sampled at accepted start.
REQ-008 SHALL have port i_start  input  DATABIT  first count value; sampled at accepted start.
REQ-009 SHALL have port i_step  input  STEPBIT  increment/decrement amount; sampled at accepted start.
REQ-010 SHALL have port i_mode_down  input  1  0 = count up, 1 = count down; sampled at accepted start.
REQ-011 SHALL have port i_reload  input  1  repeat-lap enable; live, sampled at each lap end.
REQ-012 SHALL have port i_pause  input  1  hold request; level-sensitive.
REQ-013 SHALL have port i_abort  input  1  cancel request; level-sensitive.
REQ-014 SHALL have ports o_idle, o_running, o_paused, o_done  output  1 each  one-hot state flags.
REQ-015 SHALL have port o_tick  output  1  high in every RUN cycle (current o_data is a valid count).
REQ-016 SHALL have port o_data  output  DATABIT  current count value.
REQ-017 SHALL have port o_lap  output  LAPBIT  completed laps since last accepted start.

Function
REQ-018 SHALL implement states IDLE, RUN, PAUSE, DONE; o_idle/o_running/o_paused/o_done = state decode, exactly one high.
REQ-019 IDLE: i_run=1 and i_num_cnt!=0 -> RUN; i_run=1 and i_num_cnt==0 -> DONE (no ticks, o_lap=0); latch config, clear o_lap and tick index k.
REQ-020 First RUN cycle SHALL present o_data = i_start (latched), k=0; latency i_run to first tick = 1 cycle.
REQ-021 Each RUN cycle SHALL assert o_tick and, at its end, advance: o_data +/- step (mod 2^DATABIT, wrap silently), k+1.
REQ-022 RUN with i_pause=1 and k<N-1 -> PAUSE after advancing; PAUSE holds o_data and k, o_tick=0; PAUSE with i_pause=0 -> RUN.
REQ-023 Lap end = RUN cycle with k==N-1: o_lap += 1, saturating at 2^LAPBIT-1.
REQ-024 At lap end with i_reload=1: k<=0, o_data<=latched start, next state RUN (or PAUSE if i_pause=1); with i_reload=0: next state DONE, o_data holds last value.
REQ-025 DONE SHALL last exactly one cycle -> IDLE; o_data cleared to 0 on DONE->IDLE; o_lap held until next accepted start.
REQ-026 i_abort=1 in RUN or PAUSE -> IDLE next cycle, o_data<=0, o_lap held, no DONE; abort overrides pause, lap end and reload.
REQ-027 i_run, i_abort outside their stated states SHALL be ignored; config input changes after start SHALL have no effect except i_reload.
REQ-028 k SHALL be DATABIT wide; N up to 2^DATABIT-1 supported; step of 0 legal (constant o_data).

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, o_data=0, o_lap=0, k=0, latched config=0, o_tick=0, o_idle=1.
REQ-030 reset deasserting mid-operation SHALL leave block in IDLE; no resumption of prior run.

Verification
REQ-031 Up: start=5, step=3, N=4, reload=0, run at cycle 0 -> ticks cycles 1-4 with o_data 5,8,11,14; o_done cycle 5; o_idle cycle 6, o_data=0, o_lap=1.
REQ-032 Down wrap: start=2, step=2, N=3, down -> o_data 2,0,254; DONE next; o_lap=1.
REQ-033 Pause: start=0, step=1, N=3, i_pause high during 2nd RUN cycle for 3 cycles -> ticks 0,1; PAUSE holds 2 for 2 cycles, o_tick=0; tick 2; DONE.
REQ-034 Reload: start=7, step=1, N=2, i_reload high, dropped before 3rd lap end -> 7,8,7,8,7,8; DONE; o_lap=3.
REQ-035 Abort/zero: abort in RUN of N=10 after 3 ticks -> IDLE next cycle, o_data=0, o_done never high, o_lap=0; i_num_cnt=0 start -> DONE next cycle, no tick.
REQ-036 Reset mid-PAUSE and i_run during RUN -> reset forces all REQ-029 values within same cycle; i_run in RUN changes nothing.

Source files
------------

// File: rtl/proj2_mode_cnt.sv
// Programmable up/down tick counter with lap counting, optional lap reload,
// pause and abort. One tick is presented per RUN cycle.
module proj2_mode_cnt #(
  parameter int DATABIT = 8,
  parameter int STEPBIT = 4,
  parameter int LAPBIT  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic [DATABIT-1:0] i_num_cnt,
  input  logic [DATABIT-1:0] i_start,
  input  logic [STEPBIT-1:0] i_step,
  input  logic               i_mode_down,
  input  logic               i_reload,
  input  logic               i_pause,
  input  logic               i_abort,
  output logic               o_idle,
  output logic               o_running,
  output logic               o_paused,
  output logic               o_done,
  output logic               o_tick,
  output logic [DATABIT-1:0] o_data,
  output logic [LAPBIT-1:0]  o_lap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DATABIT-1:0] cnt_q, cnt_d;
  logic [DATABIT-1:0] k_q, k_d;
  logic [LAPBIT-1:0]  lap_q, lap_d;
  logic [DATABIT-1:0] num_q, num_d;
  logic [DATABIT-1:0] start_q, start_d;
  logic [STEPBIT-1:0] step_q, step_d;
  logic               down_q, down_d;

  logic               lastTick;
  logic [DATABIT-1:0] stepExt;
  logic [DATABIT-1:0] stepped;

  assign lastTick = (k_q == (num_q - DATABIT'(1)));
  assign stepExt  = DATABIT'(step_q);
  assign stepped  = down_q ? (cnt_q - stepExt) : (cnt_q + stepExt);

  // Abort is checked first so it wins over pause, lap end and reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    lap_d   = lap_q;
    num_d   = num_q;
    start_d = start_q;
    step_d  = step_q;
    down_d  = down_q;
    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          num_d   = i_num_cnt;
          start_d = i_start;
          step_d  = i_step;
          down_d  = i_mode_down;
          lap_d   = '0;
          k_d     = '0;
          if (i_num_cnt != '0) begin
            cnt_d   = i_start;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (lastTick) begin
          lap_d = (lap_q != '1) ? (lap_q + LAPBIT'(1)) : lap_q;
          if (i_reload) begin
            k_d     = '0;
            cnt_d   = start_q;
            state_d = i_pause ? ST_PAUSE : ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d   = stepped;
          k_d     = k_q + DATABIT'(1);
          state_d = i_pause ? ST_PAUSE : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (i_abort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (!i_pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      lap_q   <= '0;
      num_q   <= '0;
      start_q <= '0;
      step_q  <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      lap_q   <= lap_d;
      num_q   <= num_d;
      start_q <= start_d;
      step_q  <= step_d;
      down_q  <= down_d;
    end
  end

  assign o_idle    = (state_q == ST_IDLE);
  assign o_running = (state_q == ST_RUN);
  assign o_paused  = (state_q == ST_PAUSE);
  assign o_done    = (state_q == ST_DONE);
  assign o_tick    = (state_q == ST_RUN);
  assign o_data    = cnt_q;
  assign o_lap     = lap_q;

endmodule

// File: tb/tb_proj2_mode_cnt.sv
// Scoreboard bench for proj2_mode_cnt: expected tick values are queued by
// the stimulus, and a monitor pops one per observed tick.
module tb_proj2_mode_cnt;

  logic       clk;
  logic       reset;
  logic       i_run;
  logic [7:0] i_num_cnt;
  logic [7:0] i_start;
  logic [3:0] i_step;
  logic       i_mode_down;
  logic       i_reload;
  logic       i_pause;
  logic       i_abort;
  logic       o_idle;
  logic       o_running;
  logic       o_paused;
  logic       o_done;
  logic       o_tick;
  logic [7:0] o_data;
  logic [7:0] o_lap;

  logic [7:0] expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  proj2_mode_cnt #(.DATABIT(8), .STEPBIT(4), .LAPBIT(8)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .i_start(i_start), .i_step(i_step), .i_mode_down(i_mode_down),
    .i_reload(i_reload), .i_pause(i_pause), .i_abort(i_abort),
    .o_idle(o_idle), .o_running(o_running), .o_paused(o_paused),
    .o_done(o_done), .o_tick(o_tick), .o_data(o_data), .o_lap(o_lap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Flags packed as {idle, running, paused, done}
  task automatic checkState(input string name, input logic [3:0] exp);
    checkOutput(name, {28'd0, o_idle, o_running, o_paused, o_done}, {28'd0, exp});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] start, input logic [3:0] step,
                               input logic [7:0] num, input logic down,
                               input logic reload);
    i_start     = start;
    i_step      = step;
    i_num_cnt   = num;
    i_mode_down = down;
    i_reload    = reload;
    i_run       = 1'b1;
    nextCycle();
    i_run       = 1'b0;
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, expQ.size(), 0);
  endtask

  // Monitor: every tick must match the oldest queued expectation.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (o_tick) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected tick: got data %0d, expected no tick", o_data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("tick data", {24'd0, o_data}, {24'd0, exp});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; i_start = '0; i_step = '0;
    i_mode_down = 1'b0; i_reload = 1'b0; i_pause = 1'b0; i_abort = 1'b0;
    #12;
    checkState("reset state", 4'b1000);
    checkOutput("reset data", {24'd0, o_data}, 0);
    checkOutput("reset lap", {24'd0, o_lap}, 0);
    checkOutput("reset tick", {31'd0, o_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();

    // Count up: 5,8,11,14 then DONE then IDLE
    expQ.push_back(8'd5); expQ.push_back(8'd8);
    expQ.push_back(8'd11); expQ.push_back(8'd14);
    applyStimulus(8'd5, 4'd3, 8'd4, 1'b0, 1'b0);
    checkState("up first tick cycle", 4'b0100);
    repeat (4) nextCycle();
    checkState("up done", 4'b0001);
    checkOutput("up done data held", {24'd0, o_data}, 14);
    nextCycle();
    checkState("up idle", 4'b1000);
    checkOutput("up idle data", {24'd0, o_data}, 0);
    checkOutput("up lap", {24'd0, o_lap}, 1);
    checkDrained("up ticks drained");

    // Count down with wrap: 2,0,254
    expQ.push_back(8'd2); expQ.push_back(8'd0); expQ.push_back(8'd254);
    applyStimulus(8'd2, 4'd2, 8'd3, 1'b1, 1'b0);
    repeat (3) nextCycle();
    checkState("down done", 4'b0001);
    checkOutput("down lap", {24'd0, o_lap}, 1);
    nextCycle();
    checkState("down idle", 4'b1000);
    checkDrained("down ticks drained");

    // Pause: ticks 0,1; two PAUSE cycles holding 2; tick 2; DONE
    expQ.push_back(8'd0); expQ.push_back(8'd1); expQ.push_back(8'd2);
    applyStimulus(8'd0, 4'd1, 8'd3, 1'b0, 1'b0);
    nextCycle();
    i_pause = 1'b1;
    nextCycle();
    checkState("pause 1", 4'b0010);
    checkOutput("pause 1 data", {24'd0, o_data}, 2);
    checkOutput("pause 1 tick", {31'd0, o_tick}, 0);
    nextCycle();
    i_pause = 1'b0;
    checkState("pause 2", 4'b0010);
    checkOutput("pause 2 data", {24'd0, o_data}, 2);
    nextCycle();
    checkState("pause resumed", 4'b0100);
    nextCycle();
    checkState("pause done", 4'b0001);
    nextCycle();
    checkDrained("pause ticks drained");

    // Reload: 7,8 x3, reload dropped before third lap end
    repeat (3) begin expQ.push_back(8'd7); expQ.push_back(8'd8); end
    applyStimulus(8'd7, 4'd1, 8'd2, 1'b0, 1'b1);
    repeat (5) nextCycle();
    i_reload = 1'b0;
    nextCycle();
    checkState("reload done", 4'b0001);
    checkOutput("reload done data", {24'd0, o_data}, 8);
    checkOutput("reload lap", {24'd0, o_lap}, 3);
    nextCycle();
    checkOutput("reload idle lap held", {24'd0, o_lap}, 3);
    checkDrained("reload ticks drained");

    // Abort after three ticks of a ten-tick lap
    expQ.push_back(8'd0); expQ.push_back(8'd1); expQ.push_back(8'd2);
    applyStimulus(8'd0, 4'd1, 8'd10, 1'b0, 1'b0);
    repeat (2) nextCycle();
    i_abort = 1'b1;
    nextCycle();
    i_abort = 1'b0;
    checkState("abort idle", 4'b1000);
    checkOutput("abort data", {24'd0, o_data}, 0);
    checkOutput("abort lap", {24'd0, o_lap}, 0);
    nextCycle();
    checkOutput("abort no done", {31'd0, o_done}, 0);
    checkDrained("abort ticks drained");

    // Lap saturation with N=1, step 0, reload held; then abort keeps lap
    repeat (260) expQ.push_back(8'd3);
    applyStimulus(8'd3, 4'd0, 8'd1, 1'b0, 1'b1);
    repeat (259) nextCycle();
    checkOutput("lap saturated", {24'd0, o_lap}, 255);
    i_abort = 1'b1;
    nextCycle();
    i_abort = 1'b0;
    i_reload = 1'b0;
    checkState("sat abort idle", 4'b1000);
    checkOutput("sat abort lap held", {24'd0, o_lap}, 255);
    checkDrained("sat ticks drained");

    // Zero lap length goes straight to DONE and clears the lap count
    applyStimulus(8'd9, 4'd1, 8'd0, 1'b0, 1'b0);
    checkState("zero N done", 4'b0001);
    checkOutput("zero N no tick", {31'd0, o_tick}, 0);
    checkOutput("zero N lap", {24'd0, o_lap}, 0);
    nextCycle();
    checkState("zero N idle", 4'b1000);

    // i_run and config changes during RUN are ignored; reset mid-PAUSE
    expQ.push_back(8'd10); expQ.push_back(8'd15); expQ.push_back(8'd10);
    applyStimulus(8'd10, 4'd5, 8'd2, 1'b0, 1'b1);
    i_run = 1'b1; i_start = 8'd99; i_step = 4'd1; i_num_cnt = 8'd7; i_mode_down = 1'b1;
    repeat (2) nextCycle();
    i_pause = 1'b1;
    nextCycle();
    i_run = 1'b0;
    checkState("pre-reset pause", 4'b0010);
    checkOutput("pre-reset data", {24'd0, o_data}, 15);
    checkOutput("pre-reset lap", {24'd0, o_lap}, 1);
    #1 reset = 1'b1;
    #1;
    checkState("async reset state", 4'b1000);
    checkOutput("async reset data", {24'd0, o_data}, 0);
    checkOutput("async reset lap", {24'd0, o_lap}, 0);
    checkOutput("async reset tick", {31'd0, o_tick}, 0);
    nextCycle();
    #3 reset = 1'b0;
    i_pause = 1'b0; i_reload = 1'b0;
    nextCycle();
    checkState("post-reset idle", 4'b1000);
    checkDrained("reset ticks drained");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
